cache_dpram_bypass: RTL and testbench

Parametrised simple-dual-port RAM for the cache data and tag arrays: one read-only port and one write-only port on a single clock. It extends the basic 1R/1W block RAM in four ways:
- per-byte write enables;
- selectable read latency of 1 or 2 cycles;
- write-to-read bypass, so a same-cycle collision returns the new data;
- registered, held read data with a valid strobe, instead of X when idle.
It sits between the cache controller and the FPGA block RAM primitives.

---
 rtl/cache_dpram_bypass.sv | 127 ++++++++++++
 tb/tb_cache_dpram_bypass.sv | 184 ++++++++++++++++++
 2 files changed

// File: rtl/cache_dpram_bypass.sv
// Simple-dual-port cache RAM: one read port, one byte-masked write port, one clock.
// Read data is registered and held; same-edge write/read collisions are merged here, not in the primitive.
module cache_dpram_bypass #(
    parameter int ADDR_WIDTH   = 4,
    parameter int DATA_WIDTH   = 32,
    parameter int BYTE_WIDTH   = 8,
    parameter int READ_LATENCY = 1,
    parameter int BYPASS       = 1
) (
    input  logic                            clk,
    input  logic                            reset,
    input  logic [ADDR_WIDTH-1:0]           addr1,
    input  logic                            re1,
    output logic [DATA_WIDTH-1:0]           data1r,
    output logic                            rvalid1,
    input  logic [ADDR_WIDTH-1:0]           addr2,
    input  logic                            we2,
    input  logic [DATA_WIDTH/BYTE_WIDTH-1:0] be2,
    input  logic [DATA_WIDTH-1:0]           data2w,
    output logic                            collide1
);
    localparam int NB    = DATA_WIDTH / BYTE_WIDTH;
    localparam int DEPTH = 1 << ADDR_WIDTH;

    if (READ_LATENCY != 1 && READ_LATENCY != 2) begin : g_bad_latency
        $error("cache_dpram_bypass: READ_LATENCY must be 1 or 2");
    end
    if (DATA_WIDTH % BYTE_WIDTH != 0) begin : g_bad_width
        $error("cache_dpram_bypass: DATA_WIDTH must be a multiple of BYTE_WIDTH");
    end

    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic [DATA_WIDTH-1:0] ram_q;
    logic [DATA_WIDTH-1:0] wdata_q;
    logic [NB-1:0]         be_q;
    logic                  rd_v_q;
    logic                  col_q;
    logic                  hit;
    logic [DATA_WIDTH-1:0] lane_mask;
    logic [DATA_WIDTH-1:0] merged;

    assign hit = re1 && we2 && (addr1 == addr2);

    // RAM array and its output register carry no reset so they map onto block RAM.
    always_ff @(posedge clk) begin
        if (!reset && we2) begin
            for (int i = 0; i < NB; i++) begin
                if (be2[i]) mem[addr2][i*BYTE_WIDTH +: BYTE_WIDTH] <= data2w[i*BYTE_WIDTH +: BYTE_WIDTH];
            end
        end
        if (!reset && re1) ram_q <= mem[addr1];
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rd_v_q  <= 1'b0;
            col_q   <= 1'b0;
            wdata_q <= '0;
            be_q    <= '0;
        end else begin
            rd_v_q <= re1;
            col_q  <= hit;
            if (re1) begin
                wdata_q <= data2w;
                be_q    <= hit ? be2 : '0;
            end
        end
    end

    // ram_q holds the pre-write contents; bypass overlays the colliding write lanes.
    always_comb begin
        lane_mask = '0;
        if (BYPASS != 0 && col_q) begin
            for (int i = 0; i < NB; i++) lane_mask[i*BYTE_WIDTH +: BYTE_WIDTH] = {BYTE_WIDTH{be_q[i]}};
        end
        merged = (ram_q & ~lane_mask) | (wdata_q & lane_mask);
    end

    logic [DATA_WIDTH-1:0] out_data_d;
    logic                  out_v_d;
    logic                  out_c_d;

    if (READ_LATENCY == 2) begin : g_lat2
        logic [DATA_WIDTH-1:0] s2_data_q;
        logic                  s2_v_q;
        logic                  s2_c_q;
        always_ff @(posedge clk or posedge reset) begin
            if (reset) begin
                s2_data_q <= '0;
                s2_v_q    <= 1'b0;
                s2_c_q    <= 1'b0;
            end else begin
                s2_v_q <= rd_v_q;
                s2_c_q <= rd_v_q && col_q;
                if (rd_v_q) s2_data_q <= merged;
            end
        end
        assign out_data_d = s2_data_q;
        assign out_v_d    = s2_v_q;
        assign out_c_d    = s2_c_q;
    end else begin : g_lat1
        assign out_data_d = merged;
        assign out_v_d    = rd_v_q;
        assign out_c_d    = col_q;
    end

    logic [DATA_WIDTH-1:0] data1r_q;
    logic                  rvalid1_q;
    logic                  collide1_q;

    // rvalid1/collide1 pulse for exactly one cycle per completed read; data1r holds otherwise.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            data1r_q   <= '0;
            rvalid1_q  <= 1'b0;
            collide1_q <= 1'b0;
        end else begin
            rvalid1_q  <= out_v_d;
            collide1_q <= out_v_d && out_c_d;
            if (out_v_d) data1r_q <= out_data_d;
        end
    end

    assign data1r   = data1r_q;
    assign rvalid1  = rvalid1_q;
    assign collide1 = collide1_q;
endmodule

// File: tb/tb_cache_dpram_bypass.sv
// Scoreboard bench for cache_dpram_bypass: three instances (RL1/bypass, RL1/read-first, RL2/bypass)
// share one stimulus stream; each has its own expected queue checked by a monitor on rvalid1.
module tb_cache_dpram_bypass;
    logic        clk;
    logic        reset;
    logic [3:0]  addr1;
    logic        re1;
    logic [3:0]  addr2;
    logic        we2;
    logic [3:0]  be2;
    logic [31:0] data2w;

    logic [31:0] d_o [3];
    logic        v_o [3];
    logic        c_o [3];

    logic [32:0] exp_q [3][$];
    int          due_q [3][$];
    logic [31:0] last_d [3];
    int          lat [3];

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    cache_dpram_bypass #(.READ_LATENCY(1), .BYPASS(1)) dut_a (
        .clk(clk), .reset(reset), .addr1(addr1), .re1(re1), .data1r(d_o[0]), .rvalid1(v_o[0]),
        .addr2(addr2), .we2(we2), .be2(be2), .data2w(data2w), .collide1(c_o[0]));
    cache_dpram_bypass #(.READ_LATENCY(1), .BYPASS(0)) dut_b (
        .clk(clk), .reset(reset), .addr1(addr1), .re1(re1), .data1r(d_o[1]), .rvalid1(v_o[1]),
        .addr2(addr2), .we2(we2), .be2(be2), .data2w(data2w), .collide1(c_o[1]));
    cache_dpram_bypass #(.READ_LATENCY(2), .BYPASS(1)) dut_c (
        .clk(clk), .reset(reset), .addr1(addr1), .re1(re1), .data1r(d_o[2]), .rvalid1(v_o[2]),
        .addr2(addr2), .we2(we2), .be2(be2), .data2w(data2w), .collide1(c_o[2]));

    // clock / reset
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input int k, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s dut%0d: got %0h expected %0h (cycle %0d)", nm, k, got, exp, cyc);
        end
    endtask

    // driver: one call sets the inputs for the next rising edge
    task automatic step(input logic re, input logic [3:0] ra, input logic we, input logic [3:0] wa,
                        input logic [31:0] wd, input logic [3:0] be,
                        input logic [31:0] exp_bp1, input logic [31:0] exp_bp0, input logic col);
        @(posedge clk);
        #1;
        re1 = re; addr1 = ra; we2 = we; addr2 = wa; data2w = wd; be2 = be;
        if (re) begin
            for (int k = 0; k < 3; k++) begin
                exp_q[k].push_back({col, (k == 1) ? exp_bp0 : exp_bp1});
                due_q[k].push_back(cyc + 1 + lat[k]);
            end
        end
    endtask

    task automatic wr(input logic [3:0] a, input logic [31:0] d, input logic [3:0] be);
        step(1'b0, 4'd0, 1'b1, a, d, be, 32'h0, 32'h0, 1'b0);
    endtask

    task automatic rd(input logic [3:0] a, input logic [31:0] e);
        step(1'b1, a, 1'b0, 4'd0, 32'h0, 4'h0, e, e, 1'b0);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 4'd0, 1'b0, 4'd0, 32'h0, 4'h0, 32'h0, 32'h0, 1'b0);
    endtask

    // monitor / scoreboard
    always @(negedge clk) begin
        for (int k = 0; k < 3; k++) begin
            if (reset) begin
                chk("reset_rvalid", k, 64'(v_o[k]), 64'd0);
                chk("reset_data", k, 64'(d_o[k]), 64'd0);
                last_d[k] = 32'h0;
            end else if (v_o[k]) begin
                if (exp_q[k].size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_rvalid dut%0d: got data %0h expected no read (cycle %0d)", k, d_o[k], cyc);
                end else begin
                    logic [32:0] e;
                    int due;
                    e   = exp_q[k].pop_front();
                    due = due_q[k].pop_front();
                    chk("rdata", k, 64'(d_o[k]), 64'(e[31:0]));
                    chk("collide", k, 64'(c_o[k]), 64'(e[32]));
                    chk("latency_cycle", k, 64'(cyc), 64'(due));
                    last_d[k] = e[31:0];
                end
            end else begin
                chk("idle_collide", k, 64'(c_o[k]), 64'd0);
                chk("hold_data", k, 64'(d_o[k]), 64'(last_d[k]));
            end
        end
    end

    initial begin
        lat[0] = 1; lat[1] = 1; lat[2] = 2;
        for (int k = 0; k < 3; k++) last_d[k] = 32'h0;
        reset = 1'b1;
        re1 = 1'b0; addr1 = '0; we2 = 1'b0; addr2 = '0; data2w = '0; be2 = '0;
        repeat (3) @(posedge clk);
        #2 reset = 1'b0;

        // basic write then read, then hold while idle
        wr(4'd3, 32'hDEADBEEF, 4'hF);
        rd(4'd3, 32'hDEADBEEF);
        idle(3);
        // be2=0 write is a no-op
        wr(4'd3, 32'h00000000, 4'h0);
        rd(4'd3, 32'hDEADBEEF);

        // byte enables
        wr(4'd5, 32'h11223344, 4'hF);
        wr(4'd5, 32'hAABBCCDD, 4'b0101);
        rd(4'd5, 32'h11BB33DD);

        // same-edge collision: bypass merges enabled lanes, read-first keeps old word
        wr(4'd7, 32'h00000000, 4'hF);
        step(1'b1, 4'd7, 1'b1, 4'd7, 32'hFFFF0000, 4'b1100, 32'hFFFF0000, 32'h00000000, 1'b1);
        rd(4'd7, 32'hFFFF0000);
        // partial-lane collision exposes the byte merge
        step(1'b1, 4'd7, 1'b1, 4'd7, 32'h12345678, 4'b0011, 32'hFFFF5678, 32'hFFFF0000, 1'b1);
        rd(4'd7, 32'hFFFF5678);

        // simultaneous read/write to different addresses
        wr(4'd2, 32'h22220000, 4'hF);
        wr(4'd9, 32'h99999999, 4'hF);
        step(1'b1, 4'd2, 1'b1, 4'd9, 32'h12345678, 4'hF, 32'h22220000, 32'h22220000, 1'b0);
        rd(4'd9, 32'h12345678);
        idle(2);

        // streaming: preload then 16 back-to-back reads
        for (int a = 0; a < 16; a++) wr(4'(a), 32'(a) * 32'h01010101, 4'hF);
        for (int a = 0; a < 16; a++) rd(4'(a), 32'(a) * 32'h01010101);
        idle(3);

        // reset mid-flight drops in-flight reads and blocks writes
        rd(4'd1, 32'h01010101);
        rd(4'd2, 32'h02020202);
        @(posedge clk);
        #2;
        reset = 1'b1;
        for (int k = 0; k < 3; k++) begin
            exp_q[k].delete();
            due_q[k].delete();
        end
        re1 = 1'b0; we2 = 1'b1; addr2 = 4'd1; data2w = 32'h55555555; be2 = 4'hF;
        repeat (2) @(posedge clk);
        #2;
        reset = 1'b0;
        we2 = 1'b0;
        idle(4);
        rd(4'd1, 32'h01010101);
        idle(1);

        // drain with a bounded wait
        for (int n = 0; n < 20; n++) begin
            if (exp_q[0].size() == 0 && exp_q[1].size() == 0 && exp_q[2].size() == 0) break;
            @(posedge clk);
        end
        for (int k = 0; k < 3; k++) begin
            checks++;
            if (exp_q[k].size() != 0) begin
                errors++;
                $display("FAIL drain_timeout dut%0d: got %0d pending reads expected 0", k, exp_q[k].size());
            end
        end
        @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
